// File: rtl/fetch_ctrl.sv
// Instruction-fetch PC sequencer: one outstanding IMem request at a time,
// decode-stage redirects (immediate or deferred), wait timeout and sticky fault.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] RDF,
  output logic        ValidF,
  output logic        BusyF,
  output logic        ErrF
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 8;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READY = 2'd1,
    ERR   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rdf_q, rdf_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            redir_c;
  logic [XLEN-1:0] redir_pc_c;
  logic [XLEN-1:0] seq_pc_c;
  logic [XLEN-1:0] next_pc_c;

  // Branch beats jump whenever both are asserted.
  assign redir_c    = PCSrcD | JumpD;
  assign redir_pc_c = PCSrcD ? PCBranchD : PCJumpD;
  assign seq_pc_c   = pc_q + XLEN'(4);

  // State register
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      rdf_q     <= '0;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rdf_q     <= rdf_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rdf_d     = rdf_q;
    pend_pc_d = pend_pc_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    next_pc_c = seq_pc_c;

    unique case (state_q)
      FETCH: begin
        if (IMemAck) begin
          cnt_d = '0;
          if (redir_c || pend_q) begin
            // Returned word belongs to a squashed path: drop it and refetch.
            next_pc_c = redir_c ? redir_pc_c : pend_pc_q;
            pend_d    = 1'b0;
            if (next_pc_c[1:0] != 2'b00) begin
              state_d = ERR;
            end else begin
              pc_d = next_pc_c;
            end
          end else begin
            rdf_d   = IMemRdata;
            state_d = READY;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (redir_c) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_pc_c;
          end
          if (cnt_d == WAIT_LIMIT) begin
            state_d = ERR;
          end
        end
      end
      READY: begin
        if (!StallF) begin
          next_pc_c = redir_c ? redir_pc_c : seq_pc_c;
          if (next_pc_c[1:0] != 2'b00) begin
            state_d = ERR;
          end else begin
            pc_d    = next_pc_c;
            state_d = FETCH;
          end
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = ERR;
      end
    endcase

    valid_d = (state_d == READY);
    err_d   = (state_d == ERR);
  end

  // Request is masked by rst so memory never sees a request during reset.
  assign IMemReq  = (state_q == FETCH) & ~rst;
  assign BusyF    = IMemReq;
  assign IMemAddr = pc_q;
  assign PCF      = pc_q;
  assign PCPlus4F = seq_pc_c;
  assign RDF      = rdf_q;
  assign ValidF   = valid_q;
  assign ErrF     = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a transaction-level fetch model pushes
// expected events (request, instruction, fault) that a monitor checks.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF0;
  localparam int          MAX_WAIT = 6;
  localparam int          NCYC     = 4000;
  localparam int          K_REQ    = 0;
  localparam int          K_INSN   = 1;
  localparam int          K_ERR    = 2;

  logic        CLK = 1'b0;
  logic        rst, StallF, PCSrcD, JumpD, IMemAck;
  logic [31:0] PCBranchD, PCJumpD, IMemRdata;
  logic        IMemReq, ValidF, BusyF, ErrF;
  logic [31:0] IMemAddr, PCF, PCPlus4F, RDF;

  fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .rst(rst), .StallF(StallF),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .JumpD(JumpD), .PCJumpD(PCJumpD),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemAck(IMemAck), .IMemRdata(IMemRdata),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .RDF(RDF),
    .ValidF(ValidF), .BusyF(BusyF), .ErrF(ErrF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] pc;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_push_cyc = -1;
  int  rst_edges = 0;

  // Reference model: where fetch stands, not how the RTL encodes it.
  bit          m_fetch, m_err, m_pend, m_newreq;
  logic [31:0] m_pc, m_tgt;
  int          m_waits;

  function automatic void push(input int kind, input logic [31:0] pc, input logic [31:0] data);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.pc = pc; e.data = data;
    exp_q.push_back(e);
    last_push_cyc = cyc;
  endfunction

  function automatic void raise_err();
    m_err   = 1'b1;
    m_fetch = 1'b0;
    push(K_ERR, m_pc, 32'h0);
  endfunction

  function automatic void model_step();
    bit          r;
    logic [31:0] rt, t;
    cyc++;
    m_newreq = 1'b0;
    if (rst) begin
      rst_edges++;
      m_fetch = 1'b1; m_err = 1'b0; m_pend = 1'b0; m_pc = RESET_PC; m_waits = 0;
      return;
    end
    rst_edges = 0;
    if (m_err) return;
    r  = PCSrcD || JumpD;
    rt = PCSrcD ? PCBranchD : PCJumpD;
    if (m_fetch) begin
      if (IMemAck) begin
        m_waits = 0;
        if (r || m_pend) begin
          t = r ? rt : m_tgt;
          m_pend = 1'b0;
          if (t[1:0] != 2'b00) raise_err();
          else begin m_pc = t; m_newreq = 1'b1; push(K_REQ, t, 32'h0); end
        end else begin
          m_fetch = 1'b0;
          push(K_INSN, m_pc, IMemRdata);
        end
      end else begin
        if (r) begin m_pend = 1'b1; m_tgt = rt; end
        m_waits++;
        if (m_waits == MAX_WAIT) raise_err();
      end
    end else if (!StallF) begin
      t = PCSrcD ? PCBranchD : (JumpD ? PCJumpD : m_pc + 32'd4);
      if (t[1:0] != 2'b00) raise_err();
      else begin m_pc = t; m_fetch = 1'b1; m_newreq = 1'b1; push(K_REQ, t, 32'h0); end
    end
  endfunction

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return MAX_WAIT;
    if (r == 1) return MAX_WAIT - 1;
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] pick_target();
    int r;
    r = int'($urandom_range(0, 39));
    if (r == 0) return (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
    if (r == 1) return 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
    end
  endtask

  task automatic take(input int kind, output bit ok, output ev_t e);
    checks++;
    ok = 1'b0;
    e.kind = -1; e.cyc = 0; e.pc = 32'h0; e.data = 32'h0;
    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
      errors++;
      $display("FAIL unexpected_event cyc=%0d got=kind%0d exp=none", cyc, kind);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_kind cyc=%0d got=kind%0d exp=kind%0d", cyc, kind, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Stimulus: memory responder, hazard/decode inputs and reset pulses.
  initial begin
    int dly = 0;
    int errhold = 0;
    int rst_left = 3;
    rst = 1'b1; StallF = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0; IMemAck = 1'b0;
    PCBranchD = 32'h0; PCJumpD = 32'h0; IMemRdata = 32'h0;
    for (int n = 0; n < NCYC; n++) begin
      @(posedge CLK);
      model_step();
      #1;
      if (m_newreq) dly = pick_delay();
      errhold = m_err ? errhold + 1 : 0;
      if (rst_left == 0 && !rst && last_push_cyc != cyc &&
          (errhold == 3 || $urandom_range(0, 299) == 0))
        rst_left = int'($urandom_range(1, 3));
      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if (rst) begin
        rst = 1'b0;
        push(K_REQ, RESET_PC, 32'h0);
        dly = pick_delay();
      end
      IMemAck = 1'b0;
      if (!rst && m_fetch) begin
        if (dly == 0) IMemAck = 1'b1;
        else dly--;
      end
      IMemRdata = ($urandom_range(0, 7) == 0) ? 32'h2008_0005 : $urandom;
      StallF    = ($urandom_range(0, 2) == 0);
      PCSrcD    = ($urandom_range(0, 5) == 0);
      JumpD     = ($urandom_range(0, 5) == 0);
      PCBranchD = pick_target();
      PCJumpD   = pick_target();
    end
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: turns DUT output changes into events and checks them in order.
  initial begin
    bit          prev_req = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0, prev_err = 1'b0;
    bit          ok;
    ev_t         e;
    logic [31:0] cur_addr = 32'h0, cur_pc = 32'h0, cur_insn = 32'h0;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event cyc=%0d got=none exp=kind%0d pc=%h", e.cyc, e.kind, e.pc);
      end
      if (rst) begin
        if (rst_edges > 0) begin
          chk("rst_pcf", PCF, RESET_PC);
          chk("rst_rdf", RDF, 32'h0);
          chk_bit("rst_valid", ValidF, 1'b0);
          chk_bit("rst_err", ErrF, 1'b0);
          chk_bit("rst_req", IMemReq, 1'b0);
          chk_bit("rst_busy", BusyF, 1'b0);
        end
      end else begin
        if (IMemReq && (!prev_req || prev_ack)) begin
          take(K_REQ, ok, e);
          if (ok) begin
            chk("req_addr", IMemAddr, e.pc);
            chk_bit("req_busy", BusyF, 1'b1);
            chk_bit("req_valid", ValidF, 1'b0);
            cur_addr = e.pc;
          end
        end else if (IMemReq) begin
          chk("req_hold_addr", IMemAddr, cur_addr);
          chk_bit("req_hold_busy", BusyF, 1'b1);
        end
        if (ValidF && !prev_valid) begin
          take(K_INSN, ok, e);
          if (ok) begin
            chk("insn_pcf", PCF, e.pc);
            chk("insn_rdf", RDF, e.data);
            chk("insn_plus4", PCPlus4F, e.pc + 32'd4);
            chk_bit("insn_req", IMemReq, 1'b0);
            chk_bit("insn_busy", BusyF, 1'b0);
            cur_pc = e.pc;
            cur_insn = e.data;
          end
        end else if (ValidF) begin
          chk("hold_pcf", PCF, cur_pc);
          chk("hold_rdf", RDF, cur_insn);
        end
        if (ErrF && !prev_err) begin
          take(K_ERR, ok, e);
          if (ok) begin
            chk("err_pcf", PCF, e.pc);
            chk_bit("err_req", IMemReq, 1'b0);
            chk_bit("err_busy", BusyF, 1'b0);
            chk_bit("err_valid", ValidF, 1'b0);
          end
        end else if (ErrF) begin
          chk_bit("err_hold_req", IMemReq, 1'b0);
          chk_bit("err_hold_valid", ValidF, 1'b0);
        end
      end
      prev_req   = IMemReq;
      prev_ack   = IMemAck;
      prev_valid = ValidF;
      prev_err   = ErrF;
    end
  end

endmodule
